vpopc_arb: RTL and testbench

Two-port scheduler in front of the shared mask-popcount pipeline (`vPopc`). It arbitrates whole operations, not single beats, between two requesters with round-robin priority, and passes the granted requester's mask beats through to the pipeline. After each end beat it holds the pipeline in a drain window so one operation's accumulator never mixes with the next. It tags each operation with its owner and returns the finished count to that requester.

---
 rtl/vpopc_arb.sv | 200 ++++++++++++++++++++
 tb/tb_vpopc_arb.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vpopc_arb.sv
// vpopc_arb: round-robin, whole-operation scheduler for two requesters sharing the vPopc pipeline.
// Define VPOPC_ARB_TAG_CHECK_EN to enable the sticky tag/valid consistency flag on err.
module vpopc_arb #(
    parameter int REQ_DATA_WIDTH  = 64,
    parameter int RESP_DATA_WIDTH = 64,
    parameter int REQ_ADDR_WIDTH  = 32,
    parameter int PIPE_LAT        = 6,
    parameter int DRAIN_CYCLES    = 6
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       req0_valid,
    output logic                       req0_ready,
    input  logic [REQ_DATA_WIDTH-1:0]  req0_m0,
    input  logic                       req0_end,
    input  logic [REQ_ADDR_WIDTH-1:0]  req0_addr,
    input  logic                       req1_valid,
    output logic                       req1_ready,
    input  logic [REQ_DATA_WIDTH-1:0]  req1_m0,
    input  logic                       req1_end,
    input  logic [REQ_ADDR_WIDTH-1:0]  req1_addr,
    output logic [REQ_DATA_WIDTH-1:0]  pop_m0,
    output logic                       pop_valid,
    output logic                       pop_end,
    output logic [REQ_ADDR_WIDTH-1:0]  pop_addr,
    input  logic [RESP_DATA_WIDTH-1:0] pop_out_vec,
    input  logic [REQ_ADDR_WIDTH-1:0]  pop_out_addr,
    input  logic                       pop_out_valid,
    output logic                       resp0_valid,
    output logic                       resp1_valid,
    output logic [RESP_DATA_WIDTH-1:0] resp_vec,
    output logic [REQ_ADDR_WIDTH-1:0]  resp_addr,
    output logic                       err
);

    localparam int CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic               owner;
    logic               owner_nxt;
    logic               last_grant;
    logic               last_grant_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_nxt;
    logic               grant;
    logic               rdy0;
    logic               rdy1;
    logic               accept;
    logic               sel_end;
    logic [REQ_DATA_WIDTH-1:0] sel_m0;
    logic [REQ_ADDR_WIDTH-1:0] sel_addr;
    logic [PIPE_LAT-1:0] tag_valid;
    logic [PIPE_LAT-1:0] tag_owner;
    logic               tail_valid;
    logic               tail_owner;
    logic               resp_fire;

    // Grant selection: IDLE arbitrates (ties go away from last_grant), otherwise the owner holds it.
    always_comb begin
        grant = owner;
        if (state == IDLE) begin
            if (req0_valid && req1_valid) begin
                grant = ~last_grant;
            end else begin
                grant = req1_valid;
            end
        end
    end

    assign sel_m0   = grant ? req1_m0   : req0_m0;
    assign sel_end  = grant ? req1_end  : req0_end;
    assign sel_addr = grant ? req1_addr : req0_addr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last_grant <= 1'b1;
            cnt        <= '0;
        end else begin
            state      <= state_nxt;
            owner      <= owner_nxt;
            last_grant <= last_grant_nxt;
            cnt        <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        owner_nxt      = owner;
        last_grant_nxt = last_grant;
        cnt_nxt        = cnt;
        rdy0           = 1'b0;
        rdy1           = 1'b0;
        unique case (state)
            IDLE: begin
                if (req0_valid || req1_valid) begin
                    rdy0           = ~grant;
                    rdy1           = grant;
                    owner_nxt      = grant;
                    last_grant_nxt = grant;
                    if (sel_end) begin
                        state_nxt = DRAIN;
                        cnt_nxt   = DRAIN_LOAD;
                    end else begin
                        state_nxt = BUSY;
                    end
                end
            end
            BUSY: begin
                rdy0 = ~owner;
                rdy1 = owner;
                if (accept && sel_end) begin
                    state_nxt = DRAIN;
                    cnt_nxt   = DRAIN_LOAD;
                end
            end
            DRAIN: begin
                if (cnt == '0) begin
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Readys are masked by reset so the combinational IDLE grant cannot leak out while held in reset.
    assign req0_ready = rst & rdy0;
    assign req1_ready = rst & rdy1;
    assign accept     = (req0_ready & req0_valid) | (req1_ready & req1_valid);

    assign pop_valid = accept;
    assign pop_m0    = accept ? sel_m0   : '0;
    assign pop_end   = accept ? sel_end  : 1'b0;
    assign pop_addr  = accept ? sel_addr : '0;

    // Owner tags travel alongside the pipeline so results come back to whoever issued the end beat.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tag_valid <= '0;
            tag_owner <= '0;
        end else begin
            tag_valid[0] <= accept & sel_end;
            tag_owner[0] <= accept & sel_end & grant;
            for (int i = 1; i < PIPE_LAT; i++) begin
                tag_valid[i] <= tag_valid[i-1];
                tag_owner[i] <= tag_owner[i-1];
            end
        end
    end

    assign tail_valid = tag_valid[PIPE_LAT-1];
    assign tail_owner = tag_owner[PIPE_LAT-1];
    assign resp_fire  = pop_out_valid & tail_valid;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            resp0_valid <= 1'b0;
            resp1_valid <= 1'b0;
            resp_vec    <= '0;
            resp_addr   <= '0;
        end else begin
            resp0_valid <= resp_fire & ~tail_owner;
            resp1_valid <= resp_fire & tail_owner;
            if (resp_fire) begin
                resp_vec  <= pop_out_vec;
                resp_addr <= pop_out_addr;
            end
        end
    end

`ifdef VPOPC_ARB_TAG_CHECK_EN
    logic err_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q <= 1'b0;
        end else if (pop_out_valid != tail_valid) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_vpopc_arb.sv
// tb_vpopc_arb: self-checking bench for vpopc_arb with a behavioural popcount pipeline and an
// operation-level scheduling model (round robin, drain spacing, result latency).
module tb_vpopc_arb;

    localparam int DW  = 64;
    localparam int AW  = 32;
    localparam int LAT = 6;
    localparam int DRN = 6;

    logic          clk;
    logic          rst;
    logic          req0_valid, req0_ready, req0_end;
    logic [DW-1:0] req0_m0;
    logic [AW-1:0] req0_addr;
    logic          req1_valid, req1_ready, req1_end;
    logic [DW-1:0] req1_m0;
    logic [AW-1:0] req1_addr;
    logic [DW-1:0] pop_m0;
    logic          pop_valid, pop_end;
    logic [AW-1:0] pop_addr;
    logic [DW-1:0] pop_out_vec;
    logic [AW-1:0] pop_out_addr;
    logic          pop_out_valid;
    logic          resp0_valid, resp1_valid;
    logic [DW-1:0] resp_vec;
    logic [AW-1:0] resp_addr;
    logic          err;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int last_model;
    logic force_out;

    vpopc_arb #(
        .REQ_DATA_WIDTH(DW), .RESP_DATA_WIDTH(DW), .REQ_ADDR_WIDTH(AW),
        .PIPE_LAT(LAT), .DRAIN_CYCLES(DRN)
    ) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_m0(req0_m0),
        .req0_end(req0_end), .req0_addr(req0_addr),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_m0(req1_m0),
        .req1_end(req1_end), .req1_addr(req1_addr),
        .pop_m0(pop_m0), .pop_valid(pop_valid), .pop_end(pop_end), .pop_addr(pop_addr),
        .pop_out_vec(pop_out_vec), .pop_out_addr(pop_out_addr), .pop_out_valid(pop_out_valid),
        .resp0_valid(resp0_valid), .resp1_valid(resp1_valid),
        .resp_vec(resp_vec), .resp_addr(resp_addr), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural stand-in for the popcount pipeline: accumulate per operation, emit LAT cycles after the end beat.
    logic [DW-1:0] acc;
    logic          pv_valid [LAT];
    logic [DW-1:0] pv_vec   [LAT];
    logic [AW-1:0] pv_addr  [LAT];

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc <= '0;
            for (int i = 0; i < LAT; i++) begin
                pv_valid[i] <= 1'b0;
                pv_vec[i]   <= '0;
                pv_addr[i]  <= '0;
            end
        end else begin
            if (pop_valid) acc <= pop_end ? '0 : acc + DW'($countones(pop_m0));
            pv_valid[0] <= pop_valid & pop_end;
            pv_vec[0]   <= acc + DW'($countones(pop_m0));
            pv_addr[0]  <= pop_addr;
            for (int i = 1; i < LAT; i++) begin
                pv_valid[i] <= pv_valid[i-1];
                pv_vec[i]   <= pv_vec[i-1];
                pv_addr[i]  <= pv_addr[i-1];
            end
        end
    end

    assign pop_out_valid = pv_valid[LAT-1] | force_out;
    assign pop_out_vec   = pv_vec[LAT-1];
    assign pop_out_addr  = pv_addr[LAT-1];

    // Response log: owner code is 1 for req0, 2 for req1, 3 if both pulse together.
    int            rq_cyc  [$];
    int            rq_own  [$];
    logic [DW-1:0] rq_vec  [$];
    logic [AW-1:0] rq_addr [$];

    always @(negedge clk) begin
        if (resp0_valid || resp1_valid) begin
            rq_cyc.push_back(cyc);
            rq_own.push_back(int'(resp0_valid) + 2 * int'(resp1_valid));
            rq_vec.push_back(resp_vec);
            rq_addr.push_back(resp_addr);
        end
    end

    // Operation table consumed by applyStimulus.
    int            nops [2];
    int            nb   [0:1][0:3];
    logic [DW-1:0] mm   [0:1][0:3][0:3];
    logic [AW-1:0] ad   [0:1][0:3];

    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clearRequests();
        req0_valid = 1'b0; req0_m0 = '0; req0_end = 1'b0; req0_addr = '0;
        req1_valid = 1'b0; req1_m0 = '0; req1_end = 1'b0; req1_addr = '0;
    endtask

    task automatic doReset();
        clearRequests();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        last_model = 1;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_rdy0"}, req0_ready, 1'b0);
        checkOutput({tag, "_rdy1"}, req1_ready, 1'b0);
        checkOutput({tag, "_popv"}, pop_valid, 1'b0);
        checkOutput({tag, "_popm0"}, pop_m0, '0);
        checkOutput({tag, "_popend"}, pop_end, 1'b0);
        checkOutput({tag, "_popaddr"}, pop_addr, '0);
        checkOutput({tag, "_resp"}, {resp0_valid, resp1_valid}, 2'b00);
        checkOutput({tag, "_rvec"}, resp_vec, '0);
        checkOutput({tag, "_raddr"}, resp_addr, '0);
        checkOutput({tag, "_err"}, err, 1'b0);
    endtask

    task automatic setOp(input int r, input int k, input int n, input logic [AW-1:0] a,
                         input logic [DW-1:0] b0, input logic [DW-1:0] b1, input logic [DW-1:0] b2);
        nb[r][k] = n; ad[r][k] = a;
        mm[r][k][0] = b0; mm[r][k][1] = b1; mm[r][k][2] = b2; mm[r][k][3] = '0;
    endtask

    // Drives the operation table with valid held high whenever a requester has work, and checks
    // end-beat accept cycles and responses against the schedule derived from the arbitration rules.
    task automatic applyStimulus(input string tag);
        int idx [2];
        int bt  [2];
        int e_end [$];
        int e_own [$];
        int e_cyc [$];
        logic [DW-1:0] e_vec [$];
        logic [AW-1:0] e_addr [$];
        int a_end [$];
        int a_own [$];
        int t, g, te, n, lim, s0;
        logic [DW-1:0] cnt;
        logic a0, a1;

        s0 = cyc;
        idx = '{0, 0};
        t = s0;
        while (idx[0] < nops[0] || idx[1] < nops[1]) begin
            if (idx[0] < nops[0] && idx[1] < nops[1]) g = 1 - last_model;
            else g = (idx[1] < nops[1]) ? 1 : 0;
            cnt = '0;
            for (int b = 0; b < nb[g][idx[g]]; b++) cnt += DW'($countones(mm[g][idx[g]][b]));
            te = t + nb[g][idx[g]] - 1;
            e_end.push_back(te);
            e_own.push_back(g + 1);
            e_cyc.push_back(te + LAT + 1);
            e_vec.push_back(cnt);
            e_addr.push_back(ad[g][idx[g]]);
            last_model = g;
            idx[g]++;
            t = te + 1 + DRN;
        end

        rq_cyc.delete(); rq_own.delete(); rq_vec.delete(); rq_addr.delete();
        idx = '{0, 0};
        bt  = '{0, 0};
        n = 0;
        while ((idx[0] < nops[0] || idx[1] < nops[1]) && n < 400) begin
            clearRequests();
            if (idx[0] < nops[0]) begin
                req0_valid = 1'b1; req0_m0 = mm[0][idx[0]][bt[0]];
                req0_end = (bt[0] == nb[0][idx[0]] - 1); req0_addr = ad[0][idx[0]];
            end
            if (idx[1] < nops[1]) begin
                req1_valid = 1'b1; req1_m0 = mm[1][idx[1]][bt[1]];
                req1_end = (bt[1] == nb[1][idx[1]] - 1); req1_addr = ad[1][idx[1]];
            end
            @(negedge clk);
            a0 = req0_valid && req0_ready;
            a1 = req1_valid && req1_ready;
            checkOutput({tag, "_one_accept"}, a0 && a1, 1'b0);
            checkOutput({tag, "_pop_valid"}, pop_valid, a0 || a1);
            checkOutput({tag, "_pop_m0"}, pop_m0, a0 ? req0_m0 : (a1 ? req1_m0 : '0));
            checkOutput({tag, "_pop_end"}, pop_end, a0 ? req0_end : (a1 ? req1_end : 1'b0));
            checkOutput({tag, "_pop_addr"}, pop_addr, a0 ? req0_addr : (a1 ? req1_addr : '0));
            if (a0) begin
                if (req0_end) begin a_end.push_back(cyc); a_own.push_back(1); idx[0]++; bt[0] = 0; end
                else bt[0]++;
            end
            if (a1) begin
                if (req1_end) begin a_end.push_back(cyc); a_own.push_back(2); idx[1]++; bt[1] = 0; end
                else bt[1]++;
            end
            @(posedge clk);
            #1;
            n++;
        end
        clearRequests();
        checkOutput({tag, "_budget"}, n < 400, 1'b1);

        lim = (e_cyc.size() > 0) ? e_cyc[$] + 2 : cyc;
        n = 0;
        while (cyc < lim && n < 400) begin
            @(posedge clk);
            n++;
        end
        #1;

        checkOutput({tag, "_n_end"}, a_end.size(), e_end.size());
        for (int i = 0; i < a_end.size() && i < e_end.size(); i++) begin
            checkOutput({tag, "_end_cyc"}, a_end[i] - s0, e_end[i] - s0);
            checkOutput({tag, "_end_own"}, a_own[i], e_own[i]);
        end
        checkOutput({tag, "_n_resp"}, rq_cyc.size(), e_cyc.size());
        for (int i = 0; i < rq_cyc.size() && i < e_cyc.size(); i++) begin
            checkOutput({tag, "_resp_cyc"}, rq_cyc[i] - s0, e_cyc[i] - s0);
            checkOutput({tag, "_resp_own"}, rq_own[i], e_own[i]);
            checkOutput({tag, "_resp_vec"}, rq_vec[i], e_vec[i]);
            checkOutput({tag, "_resp_addr"}, rq_addr[i], e_addr[i]);
        end
        checkOutput({tag, "_err"}, err, 1'b0);
    endtask

    initial begin
        force_out = 1'b0;
        clearRequests();
        rst = 1'b1;
        last_model = 1;
        #2 rst = 1'b0;

        // Reset state with both requesters pushing.
        repeat (2) @(posedge clk);
        #1;
        req0_valid = 1'b1; req0_m0 = 64'hFF; req0_end = 1'b1;
        req1_valid = 1'b1; req1_m0 = 64'hF;  req1_end = 1'b1;
        #1;
        checkAllZero("reset");
        doReset();

        // Single-beat op on req0.
        nops = '{1, 0};
        setOp(0, 0, 1, 32'h40, 64'hFF, '0, '0);
        applyStimulus("single");
        checkOutput("single_vec_const", resp_vec, 64'd8);
        checkOutput("single_addr_const", resp_addr, 32'h40);

        // Three-beat op on req1.
        nops = '{0, 1};
        setOp(1, 0, 3, 32'h1234, 64'h1, 64'h3, 64'hF0F0);
        applyStimulus("three");
        checkOutput("three_vec_const", resp_vec, 64'd11);

        // Ties after reset: req0 first, then req1, then req0 again.
        doReset();
        nops = '{1, 1};
        setOp(0, 0, 2, 32'hA0, 64'hFFFF_0000_FFFF_0000, 64'h7, '0);
        setOp(1, 0, 1, 32'hB0, 64'h3, '0, '0);
        applyStimulus("tie1");
        nops = '{1, 1};
        setOp(0, 0, 1, 32'hA4, 64'h1, '0, '0);
        setOp(1, 0, 3, 32'hB4, 64'hFF, 64'hFF00, 64'h1);
        applyStimulus("tie2");

        // Randomized operation mixes.
        for (int r = 0; r < 6; r++) begin
            nops[0] = int'($urandom_range(0, 3));
            nops[1] = int'($urandom_range(0, 3));
            if (nops[0] + nops[1] == 0) nops[0] = 1;
            for (int q = 0; q < 2; q++) begin
                for (int k = 0; k < 4; k++) begin
                    nb[q][k] = int'($urandom_range(1, 4));
                    ad[q][k] = $urandom;
                    for (int b = 0; b < 4; b++) mm[q][k][b] = {$urandom, $urandom};
                end
            end
            applyStimulus("rand");
        end

        // Reset while BUSY.
        req0_valid = 1'b1; req0_m0 = 64'hF; req0_end = 1'b0; req0_addr = 32'h77;
        repeat (2) @(posedge clk);
        #1;
        req1_valid = 1'b1; req1_m0 = 64'h3; req1_end = 1'b1;
        rst = 1'b0;
        #1;
        checkAllZero("rst_busy");
        @(posedge clk);
        #1 rst = 1'b1;
        clearRequests();
        rq_cyc.delete();
        repeat (15) @(posedge clk);
        #1;
        checkOutput("rst_busy_no_resp", rq_cyc.size(), 0);

        // Reset while DRAIN.
        last_model = 1;
        req1_valid = 1'b1; req1_m0 = 64'hFF; req1_end = 1'b1; req1_addr = 32'h88;
        @(posedge clk);
        #1;
        clearRequests();
        @(posedge clk);
        #1;
        req0_valid = 1'b1; req0_m0 = 64'h5; req0_end = 1'b1;
        rst = 1'b0;
        #1;
        checkAllZero("rst_drain");
        @(posedge clk);
        #1 rst = 1'b1;
        clearRequests();
        rq_cyc.delete();
        repeat (15) @(posedge clk);
        #1;
        checkOutput("rst_drain_no_resp", rq_cyc.size(), 0);
        last_model = 1;

        // Fresh operation after the aborted ones.
        nops = '{1, 1};
        setOp(0, 0, 2, 32'hC0, 64'h3, 64'h1, '0);
        setOp(1, 0, 1, 32'hD0, 64'hFFFF, '0, '0);
        applyStimulus("post_rst");

        // Result strobe with no tag in flight.
        rq_cyc.delete();
        force_out = 1'b1;
        @(posedge clk);
        #1 force_out = 1'b0;
        repeat (3) @(posedge clk);
        #1;
`ifdef VPOPC_ARB_TAG_CHECK_EN
        checkOutput("err_set", err, 1'b1);
        checkOutput("err_no_resp", rq_cyc.size(), 0);
        repeat (10) @(posedge clk);
        #1;
        checkOutput("err_sticky", err, 1'b1);
`else
        checkOutput("err_tied", err, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        checkOutput("err_tied_later", err, 1'b0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
